// File: rtl/seq_adder_if.sv
// Handshake/data bundle for seq_adder; sub exists only when
// SEQ_ADDER_SUB_EN is defined.
interface seq_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SEQ_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SEQ_ADDER_SUB_EN
    modport master (
        output start, a, b, sub,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );
    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/seq_adder.sv
// Digit-serial adder: DIGIT bits per clock, LSB digit first.
// Define SEQ_ADDER_SUB_EN to add the sub port and subtract path.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic      clk,
    input logic      rst_n,
    seq_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_adder: WIDTH must be >=2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             sub_q, sub_d;

    logic             sub_i;
    logic             accept;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_s;
    logic [WIDTH+DIGIT-1:0] shifted;

`ifdef SEQ_ADDER_SUB_EN
    assign sub_i = bus.sub;
`else
    assign sub_i = 1'b0;
`endif

    assign accept  = (state_q != RUN) && bus.start;
    // Inverted B plus carry-in of 1 gives A-B in two's complement
    assign dig_b   = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};
    assign dig_s   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, dig_b}
                   + {{DIGIT{1'b0}}, carry_q};
    assign shifted = {dig_s[DIGIT-1:0], acc_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    sub_d   = sub_i;
                    carry_d = sub_i;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = shifted[WIDTH+DIGIT-1:DIGIT];
                carry_d = dig_s[DIGIT];
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = shifted[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = dig_s[DIGIT];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder: 8-bit/1-digit and 16-bit/4-digit
// instances; subtract vectors run when SEQ_ADDER_SUB_EN is defined.
module tb_seq_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_adder_if #(.WIDTH(8))  b8 ();
    seq_adder_if #(.WIDTH(16)) b16 ();

    seq_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    seq_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(b16)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    logic [7:0]  last8 = 8'h00;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expected result per done pulse
    always @(negedge clk) begin
        if (rst_n && b8.done) begin
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done8: sum %0h", b8.sum);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                check("sum8", 32'(b8.sum), 32'(e[7:0]));
                check("cout8", 32'(b8.cout), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b16.done) begin
            if (q16.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done16: sum %0h", b16.sum);
            end else begin
                logic [16:0] e;
                e = q16.pop_front();
                check("sum16", 32'(b16.sum), 32'(e[15:0]));
                check("cout16", 32'(b16.cout), 32'(e[16]));
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] es,
                          input logic ec);
        b8.a = a;
        b8.b = b;
`ifdef SEQ_ADDER_SUB_EN
        b8.sub = s;
`else
        if (s) $display("note: subtract vector without SEQ_ADDER_SUB_EN");
`endif
        b8.start = 1'b1;
        q8.push_back({ec, es});
    endtask

    // Called on the negedge after the start edge (j=1)
    task automatic finish8(input logic [7:0] es, input int inj);
        int j = 1;
        int got = 0;
        int bc = 0;
        bit st = 1'b1;
        while (got == 0 && j <= 40) begin
            if (inj != 0 && j == inj) begin
                b8.start = 1'b1;
                b8.a = 8'h01;
                b8.b = 8'h01;
            end else if (inj != 0 && j == inj + 1) begin
                b8.start = 1'b0;
            end
            if (b8.busy) begin
                bc++;
                if (b8.sum !== last8) st = 1'b0;
            end
            if (b8.done) got = j;
            else begin
                @(negedge clk);
                j++;
            end
        end
        b8.start = 1'b0;
        check("latency8", 32'(got), 32'd9);
        check("busy_cycles8", 32'(bc), 32'd8);
        check("sum_hold_in_run8", 32'(st), 32'd1);
        last8 = es;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] es,
                          input logic ec, input bit now);
        if (!now) @(negedge clk);
        issue8(a, b, s, es, ec);
        @(negedge clk);
        b8.start = 1'b0;
        finish8(es, 0);
    endtask

    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input logic ec);
        int j = 1;
        int got = 0;
        int bc = 0;
        @(negedge clk);
        b16.a = a;
        b16.b = b;
        b16.start = 1'b1;
        q16.push_back({ec, es});
        @(negedge clk);
        b16.start = 1'b0;
        while (got == 0 && j <= 20) begin
            if (b16.busy) bc++;
            if (b16.done) got = j;
            else begin
                @(negedge clk);
                j++;
            end
        end
        check("latency16", 32'(got), 32'd5);
        check("busy_cycles16", 32'(bc), 32'd4);
    endtask

    initial begin
        b8.start = 1'b0;
        b8.a = '0;
        b8.b = '0;
        b16.start = 1'b0;
        b16.a = '0;
        b16.b = '0;
`ifdef SEQ_ADDER_SUB_EN
        b8.sub = 1'b0;
        b16.sub = 1'b0;
`endif
        @(negedge clk);
        check("rst_busy", 32'(b8.busy), 32'd0);
        check("rst_done", 32'(b8.done), 32'd0);
        check("rst_sum", 32'(b8.sum), 32'd0);
        check("rst_cout", 32'(b8.cout), 32'd0);
        rst_n = 1'b1;

        do_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("sum_hold_idle8", 32'(b8.sum), 32'h10);
        check("done_pulse_single8", 32'(b8.done), 32'd0);

        do_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op8(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Wrap-around, then back-to-back start held in DONE
        do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        @(negedge clk);
        b8.start = 1'b0;
        check("b2b_no_gap_busy", 32'(b8.busy), 32'd1);
        finish8(8'h46, 0);

        // Start during RUN must be ignored
        @(negedge clk);
        issue8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
        @(negedge clk);
        b8.start = 1'b0;
        finish8(8'hFF, 4);

`ifdef SEQ_ADDER_SUB_EN
        do_op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        do_op8(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        do_op8(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 1'b0);
        do_op8(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
`endif

        // Asynchronous reset mid-RUN
        @(negedge clk);
        issue8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        @(negedge clk);
        b8.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(b8.busy), 32'd0);
        check("arst_done", 32'(b8.done), 32'd0);
        check("arst_sum", 32'(b8.sum), 32'd0);
        check("arst_cout", 32'(b8.cout), 32'd0);
        q8.delete();
        last8 = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op8(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b1);

        do_op16(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        do_op16(16'h1234, 16'h4321, 16'h5555, 1'b0);
        do_op16(16'h8F0F, 16'h80F1, 16'h1000, 1'b1);

        repeat (3) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
